// File: rtl/window_filter.sv
// 3x3 window operator (Gaussian / Sobel / centre pass) with a 3-stage pipeline.
// Raster counters flag windows that are still incomplete at the top/left frame border.
module window_filter #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter bit BORDER_PASS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel00,
    input  logic [7:0] pixel01,
    input  logic [7:0] pixel02,
    input  logic [7:0] pixel10,
    input  logic [7:0] pixel11,
    input  logic [7:0] pixel12,
    input  logic [7:0] pixel20,
    input  logic [7:0] pixel21,
    input  logic [7:0] pixel22,
    input  logic       win_valid_i,
    input  logic       sof_i,
    input  logic [1:0] mode_i,
    output logic [7:0] pixel_o,
    output logic       valid_o,
    output logic       sof_o
);

    typedef enum logic [1:0] {
        MODE_GAUSS = 2'd0,
        MODE_SOBEL = 2'd1,
        MODE_PASS  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    localparam int CW = $clog2(IMG_W) + 1;
    localparam int RW = $clog2(IMG_H) + 1;

    // 1-2-1 weighted sum of three pixels
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    mode_t         r_mode;

    logic          w_sof_beat;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    mode_t         w_mode;
    logic          w_border;

    always_comb begin
        w_sof_beat = win_valid_i & sof_i;
        w_col      = w_sof_beat ? '0 : r_col;
        w_row      = w_sof_beat ? '0 : r_row;
        w_mode     = w_sof_beat ? mode_t'(mode_i) : r_mode;
        w_border   = (w_col < CW'(2)) || (w_row < RW'(2));
    end

    // Counters hold the position of the next beat; a sof beat overrides them to (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= MODE_GAUSS;
        end else if (win_valid_i) begin
            r_mode <= w_mode;
            if (w_col == CW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= (w_row == RW'(IMG_H - 1)) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    logic [9:0] r1_top, r1_mid, r1_bot, r1_left, r1_right;
    logic [7:0] r1_ctr;
    mode_t      r1_mode;
    logic       r1_border, r1_sof, r1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_top    <= '0;
            r1_mid    <= '0;
            r1_bot    <= '0;
            r1_left   <= '0;
            r1_right  <= '0;
            r1_ctr    <= '0;
            r1_mode   <= MODE_GAUSS;
            r1_border <= 1'b0;
            r1_sof    <= 1'b0;
            r1_valid  <= 1'b0;
        end else begin
            r1_top    <= wsum(pixel00, pixel01, pixel02);
            r1_mid    <= wsum(pixel10, pixel11, pixel12);
            r1_bot    <= wsum(pixel20, pixel21, pixel22);
            r1_left   <= wsum(pixel00, pixel10, pixel20);
            r1_right  <= wsum(pixel02, pixel12, pixel22);
            r1_ctr    <= pixel11;
            r1_mode   <= w_mode;
            r1_border <= w_border;
            r1_sof    <= w_sof_beat;
            r1_valid  <= win_valid_i;
        end
    end

    // Sobel gy reuses the Gaussian top/bottom row sums, which carry the same weights.
    logic [10:0] w_gx, w_gy, w_abs_gx, w_abs_gy, w_mag;
    logic [11:0] w_gauss;

    always_comb begin
        w_gx     = {1'b0, r1_right} - {1'b0, r1_left};
        w_gy     = {1'b0, r1_bot} - {1'b0, r1_top};
        w_abs_gx = w_gx[10] ? (~w_gx + 11'd1) : w_gx;
        w_abs_gy = w_gy[10] ? (~w_gy + 11'd1) : w_gy;
        w_mag    = w_abs_gx + w_abs_gy;
        w_gauss  = {2'b00, r1_top} + {1'b0, r1_mid, 1'b0} + {2'b00, r1_bot};
    end

    logic [11:0] r2_gauss;
    logic [10:0] r2_mag;
    logic [7:0]  r2_ctr;
    mode_t       r2_mode;
    logic        r2_border, r2_sof, r2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_gauss  <= '0;
            r2_mag    <= '0;
            r2_ctr    <= '0;
            r2_mode   <= MODE_GAUSS;
            r2_border <= 1'b0;
            r2_sof    <= 1'b0;
            r2_valid  <= 1'b0;
        end else begin
            r2_gauss  <= w_gauss;
            r2_mag    <= w_mag;
            r2_ctr    <= r1_ctr;
            r2_mode   <= r1_mode;
            r2_border <= r1_border;
            r2_sof    <= r1_sof;
            r2_valid  <= r1_valid;
        end
    end

    logic [7:0] w_res;

    always_comb begin
        case (r2_mode)
            MODE_GAUSS: w_res = 8'((r2_gauss + 12'd8) >> 4);
            MODE_SOBEL: w_res = (r2_mag > 11'd255) ? 8'hFF : r2_mag[7:0];
            default:    w_res = r2_ctr;
        endcase
        if (r2_border)
            w_res = BORDER_PASS ? r2_ctr : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_o <= '0;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
        end else begin
            pixel_o <= w_res;
            valid_o <= r2_valid;
            sof_o   <= r2_sof;
        end
    end

endmodule

// File: doc/window_filter.md
Name: window_filter

Overview:
- Downstream consumer of the 3x3 pixel-window generator.
- Takes one 9-pixel window per valid beat and computes a 3-stage pipelined 3x3 operator: Gaussian smoothing, Sobel edge magnitude, or centre pass-through.
- Tracks raster position with column/row counters so incomplete windows at the frame's top and left borders are replaced by a fixed border value.
- Drives the output pixel stream toward the frame writer; no backpressure, streaming only.

Parameters:
- IMG_W, 640, pixels per line; the column counter wraps at IMG_W-1.
- IMG_H, 480, lines per frame; the row counter wraps at IMG_H-1.
- BORDER_PASS, 0, border beats output 0 when 0, or centre pixel pixel11 when 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pixel00..pixel22  in  8 each  3x3 window, row-major; pixel11 is the centre.
- win_valid_i  in  1  window valid this cycle.
- sof_i  in  1  start of frame; qualified by win_valid_i; marks the window whose newest pixel is (0,0).
- mode_i  in  2  0=Gaussian, 1=Sobel, 2=pass centre, 3=reserved (behaves as 2).
- pixel_o  out  8  filtered pixel.
- valid_o  out  1  pixel_o valid.
- sof_o  out  1  sof_i delayed to align with valid_o.

Behaviour:
- Reset, asynchronous while rst=1: pixel_o=0, valid_o=0, sof_o=0, all pipeline registers 0, col=row=0, latched mode=0.
- Clocking: everything updates on the clk rising edge only; no combinational path from inputs to outputs.
- Latency: exactly 3 cycles. A beat with win_valid_i=1 at edge N produces valid_o=1 after edge N+3.
  - valid, sof and border flags travel in a 3-deep shift alongside the data.
  - Bubbles (win_valid_i=0) propagate as valid_o=0. Data registers may hold any value then; pixel_o is don't-care when valid_o=0.
- Position counters advance only on win_valid_i=1.
  - sof_i=1 on a valid beat: that beat takes col=0,row=0.
  - Otherwise col increments. At col=IMG_W-1, col wraps to 0 and row increments. At row=IMG_H-1 with col=IMG_W-1, both wrap to 0.
  - sof_i arriving mid-frame restarts the counters unconditionally.
  - After reset with no sof, the first valid beat is (0,0).
- Border flag: set for a beat when col<2 or row<2 (window not yet fully populated). Border beats output 0 or pixel11 per BORDER_PASS, regardless of mode.
- Mode latch: mode_i is captured only on a valid beat with sof_i=1 and held for the whole frame. That beat already uses the newly captured mode. mode_i changes at any other time are ignored.
- Stage 1: register the Gaussian row sums r0=p00+2p01+p02, r1=p10+2p11+p12, r2=p20+2p21+p22 (10 bits each). Also register the Sobel column and row terms. Register pixel11, border, sof, valid.
- Stage 2:
  - Gaussian: g = r0 + 2*r1 + r2 (12 bits, max 4080).
  - Sobel: gx = (p02+2p12+p22) - (p00+2p10+p20) and gy = (p20+2p21+p22) - (p00+2p01+p02), 11-bit signed, range -1020..1020; m = |gx|+|gy|, 11-bit unsigned, max 2040.
- Stage 3:
  - Gaussian: out = (g+8)>>4; 4088>>4=255, so no overflow.
  - Sobel: out = m saturated to 255.
  - Pass: out = pixel11.
  - The border mux is applied last.
- Simultaneous events: sof_i together with a counter wrap means sof wins (0,0). rst asserted mid-pipeline discards all in-flight beats; no valid_o pulses occur for them after rst deasserts.

Test Plan:
- Gaussian, IMG_W=4, IMG_H=3: sof, then 12 consecutive all-128 windows -> valid_o 3 cycles after each input. Beats with col<2 or row<2 output 0; the two interior beats (col 2,3 on row 2) output 128. sof_o is high only with the first output.
- Sobel: interior window with left column 0, middle 5, right 10 -> gx=40, gy=0, pixel_o=40. Left column 0, right column 255 -> gx=1020, pixel_o saturates to 255. Left 255, right 0 -> |gx|=1020, pixel_o=255.
- Gaussian rounding: interior window with centre 255 and all others 0 -> g=1020, (1020+8)>>4=64, pixel_o=64.
- Mode latch: frame starts with mode 0; mode_i=1 mid-frame -> Gaussian results continue. The next sof with mode_i=1 switches to Sobel on that same beat.
- Bubbles and BORDER_PASS=1: toggle win_valid_i 1/0 -> valid_o follows with 3-cycle latency and no extra pulses. Counters advance only on valid beats. Border beats output pixel11 (e.g. 77 -> 77).
- Reset mid-operation: assert rst with 3 beats in flight -> outputs go to 0 immediately (asynchronously) and no valid_o follows. After release, the first valid beat without sof is treated as (0,0) and outputs the border value.
